// File: rtl/mnist_pkg.sv
// Shared MNIST constants and types for the layer neurons and the digit argmax.
// ARGMAX_MARGIN_EN adds the runner-up margin helper.
package mnist_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int DATA_W      = 32;
  localparam int IDX_W       = 4;

  typedef logic signed [DATA_W-1:0] score_t;
  typedef logic [IDX_W-1:0]         idx_t;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} argmax_state_t;

  localparam idx_t   LAST_IDX  = idx_t'(NUM_CLASSES - 1);
  localparam score_t SCORE_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam score_t SCORE_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic [NUM_CLASSES-1:0] onehot_of(idx_t idx);
    logic [NUM_CLASSES-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

`ifdef ARGMAX_MARGIN_EN
  // best >= second always holds, so the wide difference is never negative
  function automatic score_t margin_sat(score_t best, score_t second);
    logic signed [DATA_W:0] diff;
    diff = {best[DATA_W-1], best} - {second[DATA_W-1], second};
    if (diff[DATA_W] || diff[DATA_W-1]) return SCORE_MAX;
    return score_t'(diff[DATA_W-1:0]);
  endfunction
`endif

endpackage

// File: rtl/digit_argmax_if.sv
// Score-set and result handshake bundle between the layer-2 controller and digit_argmax.
// ARGMAX_MARGIN_EN adds result_margin.
interface digit_argmax_if;
  import mnist_pkg::*;

  logic                          scores_valid;
  logic                          scores_ready;
  logic [NUM_CLASSES*DATA_W-1:0] scores_flat;
  logic                          result_valid;
  logic                          result_ready;
  idx_t                          result_digit;
  score_t                        result_score;
  logic [NUM_CLASSES-1:0]        result_onehot;
  logic                          busy;
`ifdef ARGMAX_MARGIN_EN
  score_t                        result_margin;
`endif

  modport master (
`ifdef ARGMAX_MARGIN_EN
    input  result_margin,
`endif
    output scores_valid, scores_flat, result_ready,
    input  scores_ready, result_valid, result_digit, result_score, result_onehot, busy
  );

  modport slave (
`ifdef ARGMAX_MARGIN_EN
    output result_margin,
`endif
    input  scores_valid, scores_flat, result_ready,
    output scores_ready, result_valid, result_digit, result_score, result_onehot, busy
  );

endinterface

// File: rtl/argmax_cmp.sv
// One combinational argmax step: candidate against the running best (strict >, so ties keep the lower index).
// ARGMAX_MARGIN_EN also tracks the runner-up score.
module argmax_cmp
  import mnist_pkg::*;
(
  input  score_t cand_i,
  input  idx_t   cand_idx_i,
  input  score_t best_i,
  input  idx_t   best_idx_i,
`ifdef ARGMAX_MARGIN_EN
  input  score_t second_i,
  output score_t second_o,
`endif
  output score_t best_o,
  output idx_t   best_idx_o,
  output logic   replaced_o
);

  always_comb begin
    replaced_o = (cand_i > best_i);
    best_o     = replaced_o ? cand_i     : best_i;
    best_idx_o = replaced_o ? cand_idx_i : best_idx_i;
  end

`ifdef ARGMAX_MARGIN_EN
  // A displaced best becomes the runner-up; equal scores also count, so ties give margin 0
  always_comb begin
    second_o = second_i;
    if (replaced_o)
      second_o = best_i;
    else if (cand_i > second_i)
      second_o = cand_i;
  end
`endif

endmodule

// File: rtl/digit_argmax.sv
// Captures the layer-2 score set, scans it one class per cycle and holds the winning digit until consumed.
// ARGMAX_MARGIN_EN adds result_margin (best minus runner-up, saturated).
module digit_argmax
  import mnist_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  digit_argmax_if.slave bus
);

  argmax_state_t          state_q;
  idx_t                   idx_q;
  idx_t                   best_idx_q;
  score_t                 best_q;
  score_t                 scores_q [NUM_CLASSES];
  logic                   scores_ready_q;
  logic                   result_valid_q;
  logic                   busy_q;
  idx_t                   result_digit_q;
  score_t                 result_score_q;
  logic [NUM_CLASSES-1:0] result_onehot_q;

  score_t cand;
  score_t cmp_best;
  idx_t   cmp_idx;
  logic   replaced;
`ifdef ARGMAX_MARGIN_EN
  score_t second_q;
  score_t cmp_second;
  score_t result_margin_q;
`endif

  assign cand = scores_q[idx_q];

  argmax_cmp u_cmp (
    .cand_i     (cand),
    .cand_idx_i (idx_q),
    .best_i     (best_q),
    .best_idx_i (best_idx_q),
`ifdef ARGMAX_MARGIN_EN
    .second_i   (second_q),
    .second_o   (cmp_second),
`endif
    .best_o     (cmp_best),
    .best_idx_o (cmp_idx),
    .replaced_o (replaced)
  );

  // The final compare feeds the result registers directly so no partial result is ever visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      idx_q           <= '0;
      best_idx_q      <= '0;
      best_q          <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) scores_q[i] <= '0;
      scores_ready_q  <= 1'b1;
      result_valid_q  <= 1'b0;
      busy_q          <= 1'b0;
      result_digit_q  <= '0;
      result_score_q  <= '0;
      result_onehot_q <= '0;
`ifdef ARGMAX_MARGIN_EN
      second_q        <= '0;
      result_margin_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.scores_valid && scores_ready_q) begin
            for (int i = 0; i < NUM_CLASSES; i++)
              scores_q[i] <= bus.scores_flat[i*DATA_W +: DATA_W];
            best_q         <= bus.scores_flat[DATA_W-1:0];
            best_idx_q     <= '0;
            idx_q          <= idx_t'(1);
`ifdef ARGMAX_MARGIN_EN
            second_q       <= SCORE_MIN;
`endif
            scores_ready_q <= 1'b0;
            busy_q         <= 1'b1;
            state_q        <= SCAN;
          end
        end
        SCAN: begin
          if (replaced) begin
            best_q     <= cmp_best;
            best_idx_q <= cmp_idx;
          end
`ifdef ARGMAX_MARGIN_EN
          second_q <= cmp_second;
`endif
          if (idx_q == LAST_IDX) begin
            result_digit_q  <= cmp_idx;
            result_score_q  <= cmp_best;
            result_onehot_q <= onehot_of(cmp_idx);
`ifdef ARGMAX_MARGIN_EN
            result_margin_q <= margin_sat(cmp_best, cmp_second);
`endif
            result_valid_q  <= 1'b1;
            busy_q          <= 1'b0;
            state_q         <= DONE;
          end else begin
            idx_q <= idx_q + idx_t'(1);
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            scores_ready_q <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.scores_ready  = scores_ready_q;
  assign bus.result_valid  = result_valid_q;
  assign bus.busy          = busy_q;
  assign bus.result_digit  = result_digit_q;
  assign bus.result_score  = result_score_q;
  assign bus.result_onehot = result_onehot_q;
`ifdef ARGMAX_MARGIN_EN
  assign bus.result_margin = result_margin_q;
`endif

endmodule

// File: tb/tb_digit_argmax.sv
// Directed self-checking bench for digit_argmax; margin checks compile in with ARGMAX_MARGIN_EN.
module tb_digit_argmax;
  import mnist_pkg::*;

  localparam int FLAT_W = NUM_CLASSES * DATA_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;
  int   handshakes = 0;
  score_t stim [NUM_CLASSES];

  digit_argmax_if bus();

  digit_argmax dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (bus.result_valid && bus.result_ready) handshakes++;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string pfx, input int digit, input score_t score, input score_t margin);
    logic [NUM_CLASSES-1:0] oh;
    oh = '0;
    oh[digit] = 1'b1;
    checkOutput({pfx, " valid"},  bus.result_valid,  1'b1);
    checkOutput({pfx, " digit"},  bus.result_digit,  digit);
    checkOutput({pfx, " score"},  bus.result_score,  score);
    checkOutput({pfx, " onehot"}, bus.result_onehot, oh);
`ifdef ARGMAX_MARGIN_EN
    checkOutput({pfx, " margin"}, bus.result_margin, margin);
`endif
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FLAT_W-1:0] packStim();
    logic [FLAT_W-1:0] f;
    for (int i = 0; i < NUM_CLASSES; i++) f[i*DATA_W +: DATA_W] = stim[i];
    return f;
  endfunction

  // Offers flatA, optionally keeps scores_valid high with flatB during the scan, and counts edges to result_valid
  task automatic applyStimulus(input logic [FLAT_W-1:0] flatA, input bit holdB,
                               input logic [FLAT_W-1:0] flatB, output int lat);
    int w = 0;
    while (!bus.scores_ready && w < 50) begin
      waitEdge();
      w++;
    end
    checkOutput("accept ready", bus.scores_ready, 1'b1);
    bus.scores_flat  = flatA;
    bus.scores_valid = 1'b1;
    waitEdge();
    if (holdB) bus.scores_flat = flatB;
    else       bus.scores_valid = 1'b0;
    checkOutput("scan busy", bus.busy, 1'b1);
    checkOutput("scan ready low", bus.scores_ready, 1'b0);
    lat = 0;
    while (!bus.result_valid && lat < 50) begin
      waitEdge();
      lat++;
    end
  endtask

  task automatic consume();
    bus.result_ready = 1'b1;
    waitEdge();
    bus.result_ready = 1'b0;
    checkOutput("consume valid drop", bus.result_valid, 1'b0);
  endtask

  initial begin
    logic [FLAT_W-1:0] fA, fB;
    int lat, h0, n;

    bus.scores_valid = 1'b0;
    bus.scores_flat  = '0;
    bus.result_ready = 1'b0;

    #12;
    checkOutput("reset ready",  bus.scores_ready,  1'b1);
    checkOutput("reset valid",  bus.result_valid,  1'b0);
    checkOutput("reset busy",   bus.busy,          1'b0);
    checkOutput("reset digit",  bus.result_digit,  0);
    checkOutput("reset score",  bus.result_score,  0);
    checkOutput("reset onehot", bus.result_onehot, 0);
`ifdef ARGMAX_MARGIN_EN
    checkOutput("reset margin", bus.result_margin, 0);
`endif
    waitEdge();
    rst_n = 1'b1;

    // Test 1: mixed scores, latency, consume returns to IDLE with outputs held
    stim = '{5, -3, 100, 7, 0, 0, 0, 0, 0, 99};
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkOutput("t1 latency", lat, 9);
    checkResult("t1", 2, 100, 1);
    checkOutput("t1 onehot literal", bus.result_onehot, 10'b0000000100);
    bus.result_ready = 1'b1;
    waitEdge();
    bus.result_ready = 1'b0;
    checkOutput("t1 valid drop", bus.result_valid, 1'b0);
    checkOutput("t1 ready back", bus.scores_ready, 1'b1);
    checkOutput("t1 digit held", bus.result_digit, 2);
    checkOutput("t1 score held", bus.result_score, 100);

    // Test 2: all equal -> lowest index
    for (int i = 0; i < NUM_CLASSES; i++) stim[i] = -42;
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkOutput("t2 latency", lat, 9);
    checkResult("t2", 0, -42, 0);
    consume();

    // Test 3: full signed range
    for (int i = 0; i < NUM_CLASSES - 1; i++) stim[i] = 32'h8000_0000;
    stim[9] = 32'h7FFF_FFFF;
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkResult("t3", 9, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    consume();

    // Test 4: a second set held during SCAN and DONE is ignored, then accepted once back in IDLE
    for (int i = 0; i < NUM_CLASSES; i++) stim[i] = 0;
    stim[3] = 50;
    fA = packStim();
    stim[3] = 0;
    stim[7] = 77;
    fB = packStim();
    applyStimulus(fA, 1'b1, fB, lat);
    checkOutput("t4 latency", lat, 9);
    checkResult("t4a", 3, 50, 50);
    for (int c = 0; c < 20; c++) begin
      waitEdge();
      checkOutput("t4 done ready low", bus.scores_ready, 1'b0);
      checkOutput("t4 done valid", bus.result_valid, 1'b1);
      checkOutput("t4 done digit", bus.result_digit, 3);
    end
    bus.result_ready = 1'b1;
    waitEdge();
    checkOutput("t4 idle valid", bus.result_valid, 1'b0);
    checkOutput("t4 idle ready", bus.scores_ready, 1'b1);
    checkOutput("t4 idle busy", bus.busy, 1'b0);
    waitEdge();
    bus.scores_valid = 1'b0;
    checkOutput("t4 b busy", bus.busy, 1'b1);
    n = 0;
    while (!bus.result_valid && n < 50) begin
      waitEdge();
      n++;
    end
    checkOutput("t4 b latency", n, 9);
    checkResult("t4b", 7, 77, 77);
    waitEdge();
    bus.result_ready = 1'b0;
    checkOutput("t4 b valid drop", bus.result_valid, 1'b0);

    // Test 5: reset during the scan discards the set
    for (int i = 0; i < NUM_CLASSES; i++) stim[i] = 0;
    stim[0] = 500;
    bus.scores_flat  = packStim();
    bus.scores_valid = 1'b1;
    waitEdge();
    bus.scores_valid = 1'b0;
    repeat (3) waitEdge();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5 rst valid", bus.result_valid, 1'b0);
    checkOutput("t5 rst ready", bus.scores_ready, 1'b1);
    checkOutput("t5 rst busy",  bus.busy,         1'b0);
    checkOutput("t5 rst digit", bus.result_digit, 0);
    checkOutput("t5 rst score", bus.result_score, 0);
    for (int c = 0; c < 3; c++) begin
      waitEdge();
      checkOutput("t5 held valid", bus.result_valid, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < NUM_CLASSES; i++) stim[i] = i + 1;
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkOutput("t5 latency", lat, 9);
    checkResult("t5", 9, 10, 1);
    consume();

    // Test 6: back-to-back sets with result_ready tied high
    bus.result_ready = 1'b1;
    h0 = handshakes;
    for (int i = 0; i < NUM_CLASSES; i++) stim[i] = 9 - i;
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkOutput("t6a latency", lat, 9);
    checkResult("t6a", 0, 9, 1);
    for (int i = 0; i < NUM_CLASSES; i++) stim[i] = -100;
    stim[5] = -1;
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkOutput("t6b latency", lat, 9);
    checkResult("t6b", 5, -1, 99);
    stim = '{1, 8, 3, 8, 2, 8, 0, 0, 0, 0};
    fA = packStim();
    applyStimulus(fA, 1'b0, fA, lat);
    checkOutput("t6c latency", lat, 9);
    checkResult("t6c", 1, 8, 0);
    waitEdge();
    checkOutput("t6 valid drop", bus.result_valid, 1'b0);
    repeat (3) waitEdge();
    checkOutput("t6 handshakes", handshakes - h0, 3);
    bus.result_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
